pe_stream_loader: RTL and testbench



---
 rtl/pe_stream_loader_if.sv | 22 ++
 rtl/pe_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_pe_stream_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_stream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_stream_loader_if
//  Purpose  : AXI-Stream style bundle (tdata/tvalid/tready/tlast) used for
//             both the operand input and the result output of
//             pe_stream_loader.
//  Ports    : master modport drives tdata/tvalid/tlast and observes tready;
//             slave modport observes tdata/tvalid/tlast and drives tready.
//  Revision : 1.0  initial release
// ============================================================================
interface pe_stream_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/pe_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pe_stream_loader
//  Purpose  : Front-end for the PE controller. Collects a 2*VECTOR_SIZE word
//             operand frame from an AXI-Stream slave into local RAM, pulses
//             pe_start, serves the RAM through a registered read port, waits
//             (with watchdog) for pe_done and returns the 32-bit result as a
//             single-beat packet on an AXI-Stream master.
//  Ports    : aclk / aresetn     clock, asynchronous active-low reset
//             s_axis (slave)     operand words, tlast expected on final beat
//             m_axis (master)    result word, tlast always high with tvalid
//             pe_start           one-cycle start pulse
//             pe_done            completion pulse (honoured only while waiting)
//             pe_rdaddr/rddata   RAM read port, one-cycle latency, read-first
//             pe_wrdata          result value, valid with pe_done
//             err_len            sticky: tlast misplaced or missing
//             err_timeout        sticky: pe_done not seen within TIMEOUT cycles
//  Revision : 1.0  initial release
// ============================================================================
module pe_stream_loader #(
    parameter int VECTOR_SIZE = 16,
    parameter int L_RAM_SIZE  = 6,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    pe_stream_loader_if.slave      s_axis,
    pe_stream_loader_if.master     m_axis,
    output logic                   pe_start,
    input  logic                   pe_done,
    input  logic [L_RAM_SIZE:0]    pe_rdaddr,
    output logic [31:0]            pe_rddata,
    input  logic [31:0]            pe_wrdata,
    output logic                   err_len,
    output logic                   err_timeout
);

    localparam int          c_ADDR_W    = L_RAM_SIZE + 1;
    localparam int          c_DEPTH     = 1 << c_ADDR_W;
    localparam int          c_FRAME_LEN = 2 * VECTOR_SIZE;
    localparam int          c_WD_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST_BEAT = c_ADDR_W'(c_FRAME_LEN - 1);
    localparam logic [c_WD_W-1:0]   c_WD_MAX    = c_WD_W'(TIMEOUT - 1);
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

    generate
        if (c_FRAME_LEN > c_DEPTH) begin : g_size_check
            $error("pe_stream_loader: frame does not fit in local RAM");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s_tready;
    logic [c_ADDR_W-1:0] r_beat_cnt;
    logic [c_WD_W-1:0]   r_wd;
    logic [31:0]         r_result;
    logic                r_err_len;
    logic                r_err_timeout;
    logic [31:0]         r_rddata;
    logic [31:0]         r_mem [c_DEPTH];

    logic                w_accept;
    logic                w_last_beat;
    logic                w_timeout_hit;

    // tready is registered so it stays low throughout reset and only rises on
    // the first edge after release; it is therefore also the fill qualifier.
    assign w_accept      = s_axis.tvalid && r_s_tready;
    assign w_last_beat   = (r_beat_cnt == c_LAST_BEAT);
    assign w_timeout_hit = (r_wd == c_WD_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_accept && w_last_beat)          w_state_nxt = S_START;
            S_START:                                       w_state_nxt = S_WAIT;
            S_WAIT:  if (pe_done || w_timeout_hit)         w_state_nxt = S_OUT;
            S_OUT:   if (m_axis.tready)                    w_state_nxt = S_FILL;
            default:                                       w_state_nxt = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, result and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_FILL;
            r_s_tready    <= 1'b0;
            r_beat_cnt    <= '0;
            r_wd          <= '0;
            r_result      <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_rddata      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s_tready <= (w_state_nxt == S_FILL);

            // Frame length comes from the beat counter only; tlast is merely
            // audited against it.
            if (w_accept) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                if (s_axis.tlast != w_last_beat) begin
                    r_err_len <= 1'b1;
                end
            end

            if (r_state == S_WAIT && w_state_nxt == S_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end

            // pe_done takes priority over a coincident watchdog expiry.
            if (r_state == S_WAIT) begin
                if (pe_done) begin
                    r_result <= pe_wrdata;
                end else if (w_timeout_hit) begin
                    r_result      <= c_QNAN;
                    r_err_timeout <= 1'b1;
                end
            end

            // Non-blocking read of the array gives read-first behaviour.
            r_rddata <= r_mem[pe_rdaddr];
        end
    end

    // RAM array has no reset so it maps onto block RAM.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_mem[r_beat_cnt] <= s_axis.tdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis.tready = r_s_tready;
    assign m_axis.tvalid = (r_state == S_OUT);
    assign m_axis.tlast  = (r_state == S_OUT);
    assign m_axis.tdata  = r_result;
    assign pe_start      = (r_state == S_START);
    assign pe_rddata     = r_rddata;
    assign err_len       = r_err_len;
    assign err_timeout   = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pe_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_stream_loader
//  Purpose  : Self-checking bench for pe_stream_loader. Stimulus pushes
//             expected results into a queue; an independent monitor pops and
//             compares whenever the result stream is valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_stream_loader;

    localparam int          VECTOR_SIZE = 16;
    localparam int          L_RAM_SIZE  = 6;
    localparam int          TIMEOUT     = 1024;
    localparam int          FRAME_LEN   = 2 * VECTOR_SIZE;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic                pe_start;
    logic                pe_done;
    logic [L_RAM_SIZE:0] pe_rdaddr;
    logic [31:0]         pe_rddata;
    logic [31:0]         pe_wrdata;
    logic                err_len;
    logic                err_timeout;

    pe_stream_loader_if #(.DATA_W(32)) s_if ();
    pe_stream_loader_if #(.DATA_W(32)) m_if ();

    pe_stream_loader #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .L_RAM_SIZE  (L_RAM_SIZE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pe_start    (pe_start),
        .pe_done     (pe_done),
        .pe_rdaddr   (pe_rdaddr),
        .pe_rddata   (pe_rddata),
        .pe_wrdata   (pe_wrdata),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #5 aclk = ~aclk;

    longint cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        tout;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame     [FRAME_LEN];
    logic [31:0] model_mem [FRAME_LEN];
    bit          exp_err_len = 1'b0;
    bit          exp_err_to  = 1'b0;
    int          exp_starts  = 0;

    int          errors = 0;
    int          checks = 0;
    int          start_cnt = 0;
    bit          rise_seen = 1'b0;
    longint      rise_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bail(input string name);
        errors++;
        checks++;
        $display("FAIL %s: bound expired waiting on DUT", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "aborted");
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge aclk);
            if (pe_start === 1'b1) start_cnt++;
            if (aresetn === 1'b1 && m_if.tvalid === 1'b1) begin
                if (!prev_v) begin
                    rise_cyc  = cyc;
                    rise_seen = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("m_tdata", m_if.tdata, exp_q[0].data);
                    chk("m_tlast", {31'd0, m_if.tlast}, 32'd1);
                    chk("err_timeout_at_out", {31'd0, err_timeout}, {31'd0, exp_q[0].tout});
                    if (m_if.tready === 1'b1) void'(exp_q.pop_front());
                end
            end
            prev_v = (m_if.tvalid === 1'b1);
        end
    end

    // Global guard against a hung run.
    initial begin
        #500000;
        bail("global_timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"},    {31'd0, s_if.tready},  32'd0);
        chk({tag, "_pe_start"},    {31'd0, pe_start},     32'd0);
        chk({tag, "_pe_rddata"},   pe_rddata,             32'd0);
        chk({tag, "_m_tvalid"},    {31'd0, m_if.tvalid},  32'd0);
        chk({tag, "_m_tdata"},     m_if.tdata,            32'd0);
        chk({tag, "_m_tlast"},     {31'd0, m_if.tlast},   32'd0);
        chk({tag, "_err_len"},     {31'd0, err_len},      32'd0);
        chk({tag, "_err_timeout"}, {31'd0, err_timeout},  32'd0);
    endtask

    // Called at posedge+1; asserts reset asynchronously mid-cycle.
    task automatic do_reset(input string tag);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs(tag);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        exp_err_len = 1'b0;
        exp_err_to  = 1'b0;
        exp_q.delete();
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);
        chk({tag, "_tready_before_edge"}, {31'd0, s_if.tready}, 32'd0);
        @(posedge aclk); #1;
        chk({tag, "_tready_after_edge"}, {31'd0, s_if.tready}, 32'd1);
    endtask

    task automatic send_frame(input int nbeats, input int bad_pos, input bit last_ok,
                              input bit gaps, output longint tcyc);
        bit acc;
        int n;
        int gap;
        for (int k = 0; k < nbeats; k++) begin
            gap = gaps ? $urandom_range(0, 2) : 0;
            if (gap != 0) begin
                s_if.tvalid = 1'b0;
                repeat (gap) begin @(posedge aclk); #1; end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = frame[k];
            s_if.tlast  = (k == FRAME_LEN - 1) ? last_ok : (k == bad_pos);
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = (s_if.tready === 1'b1);
                @(posedge aclk); #1;
                n++;
                if (n > 200) bail("s_tready_wait");
            end
            model_mem[k] = frame[k];
            if (s_if.tlast != (k == FRAME_LEN - 1)) exp_err_len = 1'b1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        tcyc = cyc;
    endtask

    task automatic check_start();
        @(negedge aclk);
        chk("pe_start_pulse", {31'd0, pe_start}, 32'd1);
        chk("s_tready_low_after_frame", {31'd0, s_if.tready}, 32'd0);
        @(negedge aclk);
        chk("pe_start_single", {31'd0, pe_start}, 32'd0);
        @(posedge aclk); #1;
        chk("start_count", start_cnt, exp_starts);
        chk("err_len", {31'd0, err_len}, {31'd0, exp_err_len});
    endtask

    task automatic sweep();
        for (int k = 0; k < FRAME_LEN; k++) begin
            pe_rdaddr = (L_RAM_SIZE + 1)'(k);
            @(posedge aclk);
            @(negedge aclk);
            chk("pe_rddata", pe_rddata, model_mem[k]);
            @(posedge aclk); #1;
        end
    endtask

    task automatic collect(input longint exp_rise, input int hold);
        int n;
        n = 0;
        while (!rise_seen) begin
            @(posedge aclk); #1;
            n++;
            if (n > TIMEOUT + 100) bail("m_tvalid_wait");
        end
        chk("tvalid_rise_cycle", 32'(rise_cyc), 32'(exp_rise));
        repeat (hold) begin @(posedge aclk); #1; end
        @(negedge aclk);
        chk("m_tvalid_held", {31'd0, m_if.tvalid}, 32'd1);
        @(posedge aclk); #1;
        m_if.tready = 1'b1;
        @(posedge aclk); #1;
        m_if.tready = 1'b0;
        @(negedge aclk);
        chk("s_tready_after_result", {31'd0, s_if.tready}, 32'd1);
        chk("m_tvalid_dropped", {31'd0, m_if.tvalid}, 32'd0);
        @(posedge aclk); #1;
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic run_frame(input int bad_pos, input bit last_ok, input bit tout,
                             input int latency, input logic [31:0] wdata,
                             input int hold, input bit gaps);
        longint tcyc;
        longint exp_rise;
        exp_t   e;
        rise_seen = 1'b0;
        send_frame(FRAME_LEN, bad_pos, last_ok, gaps, tcyc);
        exp_starts++;
        check_start();
        sweep();
        if (tout) begin
            exp_err_to = 1'b1;
            e.data = QNAN;
            e.tout = 1'b1;
            exp_q.push_back(e);
            exp_rise = tcyc + 1 + TIMEOUT;
        end else begin
            repeat (latency) begin @(posedge aclk); #1; end
            e.data = wdata;
            e.tout = exp_err_to;
            exp_q.push_back(e);
            pe_wrdata = wdata;
            pe_done   = 1'b1;
            @(posedge aclk); #1;
            exp_rise  = cyc;
            pe_done   = 1'b0;
            pe_wrdata = $urandom;
        end
        collect(exp_rise, hold);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        longint tdummy;
        aresetn     = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        pe_done     = 1'b0;
        pe_wrdata   = 32'h0;
        pe_rdaddr   = '0;

        repeat (3) @(posedge aclk);
        #1 check_reset_outputs("por");
        s_if.tvalid = 1'b0;
        #2 aresetn = 1'b1;
        @(negedge aclk);
        chk("por_tready_before_edge", {31'd0, s_if.tready}, 32'd0);
        @(posedge aclk); #1;
        chk("por_tready_after_edge", {31'd0, s_if.tready}, 32'd1);

        // Counting pattern, clean tlast, result held for 5 cycles.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = 32'(k + 1);
        run_frame(-1, 1'b1, 1'b0, 3, 32'h4200_0000, 5, 1'b0);

        // tlast early on beat 9 and missing on the final beat.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = $urandom;
        run_frame(9, 1'b0, 1'b0, $urandom_range(0, 10), $urandom, 2, 1'b1);

        // No pe_done: watchdog result.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = $urandom;
        run_frame(-1, 1'b1, 1'b1, 0, 32'h0, 1, 1'b1);

        // A pe_done outside the wait state must be ignored.
        pe_wrdata = 32'hDEAD_BEEF;
        pe_done   = 1'b1;
        @(posedge aclk); #1;
        pe_done   = 1'b0;
        repeat (3) begin @(posedge aclk); #1; end
        chk("late_done_no_output", {31'd0, m_if.tvalid}, 32'd0);
        chk("late_done_still_fill", {31'd0, s_if.tready}, 32'd1);
        chk("err_timeout_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset after beat 7 of a frame.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = $urandom;
        send_frame(8, -1, 1'b1, 1'b0, tdummy);
        do_reset("mid_frame_reset");

        for (int k = 0; k < FRAME_LEN; k++) frame[k] = 32'h100 + 32'(k);
        run_frame(-1, 1'b1, 1'b0, 4, $urandom, 0, 1'b0);

        // Reset while waiting for pe_done.
        for (int k = 0; k < FRAME_LEN; k++) frame[k] = $urandom;
        send_frame(FRAME_LEN, -1, 1'b1, 1'b1, tdummy);
        exp_starts++;
        check_start();
        repeat (10) begin @(posedge aclk); #1; end
        do_reset("mid_wait_reset");

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            int bad;
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME_LEN - 2)) : -1;
            for (int k = 0; k < FRAME_LEN; k++) frame[k] = $urandom;
            run_frame(bad, ($urandom_range(0, 3) != 0), 1'b0, $urandom_range(0, 20),
                      $urandom, $urandom_range(0, 4), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
